// File: rtl/pwm_output_stage_if.sv
// Sample-side signal bundle for pwm_output_stage: strobe, streaming state,
// per-channel duty codes in, PWM pins and status out.
interface pwm_output_stage_if #(
    parameter int unsigned CODE_W = 7
);
    logic              Clk_Ena;
    logic              Active;
    logic [CODE_W-1:0] Code_L;
    logic [CODE_W-1:0] Code_R;
    logic [1:0]        PWM;
    logic              Running;
    logic              Ramping;

    modport master (
        output Clk_Ena, Active, Code_L, Code_R,
        input  PWM, Running, Ramping
    );

    modport slave (
        input  Clk_Ena, Active, Code_L, Code_R,
        output PWM, Running, Ramping
    );
endinterface

// File: rtl/pwm_output_stage.sv
// Two-channel single-edge PWM output stage with pop-free ramp start/stop.
// Optional macro PWM_CENTRE_ALIGNED_EN switches to centre-aligned pulses.
module pwm_output_stage #(
    parameter int unsigned CODE_W   = 7,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned RAMP_DIV = 64,
    parameter int unsigned PERIOD   = 130
) (
    input  logic              Clk,
    input  logic              nReset,
    pwm_output_stage_if.slave bus
);
    localparam int unsigned       DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CODE_W-1:0] MID      = CODE_W'(2 ** (CODE_W - 1));
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    if (CNT_W <= CODE_W || PERIOD >= (1 << CNT_W)) begin : g_cfg_check
        $error("pwm_output_stage: CNT_W must exceed CODE_W and hold PERIOD");
    end

    typedef enum logic [1:0] {S_OFF, S_RAMP_UP, S_RUN, S_RAMP_DOWN} state_t;

    state_t            state, state_nxt;
    logic [CODE_W-1:0] ramp, ramp_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [CODE_W-1:0] duty_sel_l, duty_sel_r;
    logic [CNT_W-1:0]  count;
    logic [CODE_W-1:0] duty_l, duty_r;
    logic [1:0]        pwm_nxt, pwm_q;
    logic              running_q, ramping_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= S_OFF;
            ramp  <= '0;
            div   <= '0;
        end else if (bus.Clk_Ena) begin
            state <= state_nxt;
            ramp  <= ramp_nxt;
            div   <= div_nxt;
        end
    end

    // Duty select is taken from the present state, except on the strobe that
    // completes the ramp, which already hands MID to the first RUN period.
    always_comb begin
        state_nxt  = state;
        ramp_nxt   = ramp;
        div_nxt    = div;
        duty_sel_l = '0;
        duty_sel_r = '0;
        unique case (state)
            S_OFF: begin
                if (bus.Active) begin
                    state_nxt = S_RAMP_UP;
                    ramp_nxt  = '0;
                    div_nxt   = '0;
                end
            end
            S_RAMP_UP: begin
                duty_sel_l = ramp;
                duty_sel_r = ramp;
                if (!bus.Active) begin
                    state_nxt = S_RAMP_DOWN;
                    div_nxt   = '0;
                end else if (ramp == MID) begin
                    state_nxt = S_RUN;
                end else if (div == DIV_LAST) begin
                    div_nxt  = '0;
                    ramp_nxt = ramp + 1'b1;
                    if ((ramp + 1'b1) == MID) begin
                        state_nxt  = S_RUN;
                        duty_sel_l = MID;
                        duty_sel_r = MID;
                    end
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            S_RUN: begin
                duty_sel_l = bus.Code_L;
                duty_sel_r = bus.Code_R;
                if (!bus.Active) begin
                    state_nxt = S_RAMP_DOWN;
                    ramp_nxt  = MID;
                    div_nxt   = '0;
                end
            end
            S_RAMP_DOWN: begin
                duty_sel_l = ramp;
                duty_sel_r = ramp;
                if (bus.Active) begin
                    state_nxt = S_RAMP_UP;
                    div_nxt   = '0;
                end else if (ramp == '0) begin
                    state_nxt = S_OFF;
                end else if (div == DIV_LAST) begin
                    div_nxt  = '0;
                    ramp_nxt = ramp - 1'b1;
                    if (ramp == CODE_W'(1)) state_nxt = S_OFF;
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef PWM_CENTRE_ALIGNED_EN
    logic [CNT_W-1:0] start_l, start_r;

    function automatic logic [CNT_W-1:0] centre_start(input logic [CODE_W-1:0] d);
        int unsigned dd;
        dd = d;
        if (dd >= PERIOD) return '0;
        return CNT_W'((PERIOD - dd) >> 1);
    endfunction

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            start_l <= '0;
            start_r <= '0;
        end else if (bus.Clk_Ena) begin
            start_l <= centre_start(duty_sel_l);
            start_r <= centre_start(duty_sel_r);
        end
    end

    always_comb begin
        pwm_nxt    = '0;
        pwm_nxt[0] = (count >= start_l) &&
                     ({1'b0, count} < ({1'b0, start_l} + {1'b0, CNT_W'(duty_l)}));
        pwm_nxt[1] = (count >= start_r) &&
                     ({1'b0, count} < ({1'b0, start_r} + {1'b0, CNT_W'(duty_r)}));
    end
`else
    always_comb begin
        pwm_nxt    = '0;
        pwm_nxt[0] = CNT_W'(duty_l) > count;
        pwm_nxt[1] = CNT_W'(duty_r) > count;
    end
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count  <= '0;
            duty_l <= '0;
            duty_r <= '0;
        end else if (bus.Clk_Ena) begin
            count  <= '0;
            duty_l <= duty_sel_l;
            duty_r <= duty_sel_r;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pwm_q     <= '0;
            running_q <= 1'b0;
            ramping_q <= 1'b0;
        end else begin
            pwm_q     <= pwm_nxt;
            running_q <= (state == S_RUN);
            ramping_q <= (state == S_RAMP_UP) || (state == S_RAMP_DOWN);
        end
    end

    assign bus.PWM     = pwm_q;
    assign bus.Running = running_q;
    assign bus.Ramping = ramping_q;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed self-checking bench for pwm_output_stage (RAMP_DIV=4, leading-edge build).
module tb_pwm_output_stage;
    logic Clk = 1'b0;
    logic nReset;
    int   total = 0;
    int   bad   = 0;
    int   hl, hr, fr;
    int   exp_d;
    int   exp_tab[20] = '{10, 10, 10, 10, 10, 9, 9, 9, 9, 8, 8, 8, 8, 7, 7, 7, 7, 7, 7, 8};
    bit [19:0] act_bits = 20'hFC000;

    pwm_output_stage_if #(.CODE_W(7)) bus ();

    pwm_output_stage #(
        .CODE_W  (7),
        .CNT_W   (8),
        .RAMP_DIV(4),
        .PERIOD  (130)
    ) dut (
        .Clk   (Clk),
        .nReset(nReset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample period of n clocks: strobe edge first, then n-1 idle edges.
    task automatic run_period(input int n, output int h_l, output int h_r, output int f_r);
        h_l = 0;
        h_r = 0;
        f_r = -1;
        bus.Clk_Ena = 1'b1;
        @(negedge Clk);
        bus.Clk_Ena = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge Clk);
            if (bus.PWM[0]) h_l++;
            if (bus.PWM[1]) begin
                h_r++;
                if (f_r < 0) f_r = i;
            end
        end
    endtask

    initial begin
        nReset      = 1'b0;
        bus.Clk_Ena = 1'b0;
        bus.Active  = 1'b0;
        bus.Code_L  = '0;
        bus.Code_R  = '0;
        #1;
        check("reset_pwm", int'(bus.PWM), 0);
        check("reset_running", int'(bus.Running), 0);
        check("reset_ramping", int'(bus.Ramping), 0);
        @(negedge Clk);
        @(negedge Clk);
        nReset = 1'b1;

        // Ramp up from OFF; the completing strobe already carries MID.
        bus.Active = 1'b1;
        bus.Code_L = 7'd100;
        bus.Code_R = 7'd127;
        for (int s = 1; s <= 257; s++) begin
            exp_d = (s == 257) ? 64 : (s < 2) ? 0 : (s - 2) / 4;
            run_period(70, hl, hr, fr);
            check("ramp_up_l", hl, exp_d);
            check("ramp_up_r", hr, exp_d);
            check("ramp_up_ramping", int'(bus.Ramping), (s < 257) ? 1 : 0);
        end
        check("run_running", int'(bus.Running), 1);

        run_period(130, hl, hr, fr);
        check("run_l100", hl, 100);
        check("run_r127", hr, 127);
        check("run_r_first", fr, 1);

        bus.Code_L = 7'd0;
        run_period(130, hl, hr, fr);
        check("run_l0", hl, 0);
        check("run_r127b", hr, 127);
        check("run_r_firstb", fr, 1);

        bus.Code_R = 7'd120;
        run_period(90, hl, hr, fr);
        check("trunc_r_first", hr, 89);
        run_period(90, hl, hr, fr);
        check("trunc_r_second", hr, 90);
        check("trunc_l0", hl, 0);

        // Asynchronous reset in the middle of a high pulse.
        bus.Clk_Ena = 1'b1;
        @(negedge Clk);
        bus.Clk_Ena = 1'b0;
        repeat (10) @(negedge Clk);
        check("pre_reset_pwm_r", int'(bus.PWM[1]), 1);
        check("pre_reset_running", int'(bus.Running), 1);
        #2 nReset = 1'b0;
        #1;
        check("async_reset_pwm", int'(bus.PWM), 0);
        check("async_reset_running", int'(bus.Running), 0);
        check("async_reset_ramping", int'(bus.Ramping), 0);
        @(negedge Clk);
        nReset     = 1'b1;
        bus.Active = 1'b0;
        run_period(70, hl, hr, fr);
        check("post_reset_l", hl, 0);
        check("post_reset_r", hr, 0);
        check("post_reset_running", int'(bus.Running), 0);
        check("post_reset_ramping", int'(bus.Ramping), 0);

        // Fast ramp back to RUN, then ramp down.
        bus.Active = 1'b1;
        bus.Code_L = 7'd50;
        bus.Code_R = 7'd50;
        for (int s = 1; s <= 257; s++) begin
            run_period((s == 257) ? 70 : 20, hl, hr, fr);
        end
        check("rerun_running", int'(bus.Running), 1);
        run_period(130, hl, hr, fr);
        check("rerun_l50", hl, 50);
        check("rerun_r50", hr, 50);

        bus.Active = 1'b0;
        for (int d = 1; d <= 258; d++) begin
            exp_d = (d == 1) ? 50 : (d <= 257) ? 64 - (d - 2) / 4 : 0;
            run_period(70, hl, hr, fr);
            check("ramp_down_l", hl, exp_d);
            check("ramp_down_r", hr, exp_d);
            check("ramp_down_running", int'(bus.Running), 0);
            check("ramp_down_ramping", int'(bus.Ramping), (d <= 256) ? 1 : 0);
        end
        check("off_pwm", int'(bus.PWM), 0);

        // Reverse direction mid-ramp: up to 10, down to 7, back up.
        bus.Active = 1'b1;
        for (int u = 1; u <= 42; u++) begin
            exp_d = (u < 2) ? 0 : (u - 2) / 4;
            run_period(70, hl, hr, fr);
            check("rev_up_l", hl, exp_d);
        end
        for (int k = 0; k < 20; k++) begin
            bus.Active = act_bits[k];
            run_period(70, hl, hr, fr);
            check("rev_tab_l", hl, exp_tab[k]);
            check("rev_tab_r", hr, exp_tab[k]);
            check("rev_tab_ramping", int'(bus.Ramping), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
- Final audio output stage. Sits directly downstream of the per-channel noise shapers and drives the two Audio_Out pins.
- Latches one CODE_W-bit duty code per channel on each 384 kHz sample strobe and generates single-edge PWM.
- Sequences pop-free start/stop: duty ramps 0 -> midscale when Active rises, and midscale -> 0 when Active falls, before the outputs are handed over to or released from the shaper codes.

Parameters:
- CODE_W, 7, width of each duty code; midscale MID = 2^(CODE_W-1) = 64.
- CNT_W, 8, width of the in-period clock counter; must satisfy 2^CNT_W > 2^CODE_W.
- RAMP_DIV, 64, sample strobes per 1-LSB ramp step. Default gives 64*64/384k ≈ 10.7 ms per full ramp.
- PERIOD, 130, nominal clocks per sample period (50 MHz / 384 kHz). Used only by the optional feature.

Ports:
- Clk, input, 1, system clock, 50 MHz.
- nReset, input, 1, asynchronous active-low reset.
- Clk_Ena, input, 1, one-cycle sample strobe at 384 kHz (rising edge of Clk_384k).
- Active, input, 1, USB audio streaming active; level input, synchronous to Clk.
- Code_L, input, CODE_W, left duty code from noise shaper; offset binary, 0..2^CODE_W-1.
- Code_R, input, CODE_W, right duty code from noise shaper; same format as Code_L.
- PWM, output, 2, registered PWM outputs; bit 0 is L, bit 1 is R.
- Running, output, 1, high in state RUN only.
- Ramping, output, 1, high in RAMP_UP or RAMP_DOWN.

Behaviour:
- Reset (nReset=0, async): state=OFF, Count=0, Duty_L=Duty_R=0, Ramp=0, Div=0, PWM=2'b00, Running=0, Ramping=0. Release is synchronous to Clk.
- Counter: on a Clk edge with Clk_Ena=1, Count<=0. Otherwise Count<=Count+1, saturating at 2^CNT_W-1 (never wraps).
- Duty latch, on Clk_Ena edge only, from the present state:
  - OFF: duty 0.
  - RAMP_*: duty Ramp on both channels.
  - RUN: Code_L / Code_R.
- PWM[c] <= {1'b0,Duty_c} > Count, registered. High for exactly Duty_c clocks per period, starting 1 clock after the strobe edge. Duty 0 gives constant low.
- A strobe arriving before Duty clocks have elapsed truncates the pulse. No error flag.
- State machine: advances only on Clk_Ena edges; Active is sampled on those edges.
  - OFF: Active=1 -> RAMP_UP with Ramp=0, Div=0.
  - RAMP_UP: Div counts 0..RAMP_DIV-1. On wrap, Ramp+1. When Ramp reaches MID, go to RUN; that strobe already latches MID. Active=0 -> RAMP_DOWN, keeping the current Ramp and clearing Div.
  - RUN: Active=0 -> RAMP_DOWN with Ramp=MID, Div=0. The step from the last code to MID is accepted.
  - RAMP_DOWN: Ramp-1 per RAMP_DIV strobes. When Ramp reaches 0, go to OFF. Active=1 -> RAMP_UP from the current Ramp.
- Duty applied in a given period is chosen by the state before the transition on that strobe. The one exception is the MID-reached strobe above.
- Running and Ramping are registered and decoded from the state; they update one clock after a state change.
- If Clk_Ena stops: Count saturates, Duty holds, and PWM stays at its last level (low once Count ≥ Duty).
- Clk_Ena held high continuously: Count stays 0 and PWM = (Duty>0) constant. Tolerated, not a supported mode.

Optional Feature:
- Macro: PWM_CENTRE_ALIGNED_EN.
- Defined: pulses are centre-aligned. PWM[c] <= (Count >= S_c) && (Count < S_c+Duty_c), where S_c = (PERIOD - Duty_c) >> 1 is computed at the latch, with width CNT_W. Duty 0 gives constant low.
- Not defined: leading-edge behaviour as above. PERIOD is unused.

Test Plan:
- Reset mid-period, with PWM high and state RUN: assert nReset=0 asynchronously -> PWM=00, Running=0 immediately, without waiting for a Clk edge; after release, state=OFF.
- Active=1, strobe every 130 clocks, RAMP_DIV=4 -> duty increments 0,1,2… every 4 strobes. Running=1 after 256 strobes; on the next period PWM_L is high for Code_L clocks (Code_L=100 gives 100 clocks).
- RUN with Code_L=0, Code_R=127 -> PWM_L constant low; PWM_R high 127 of 130 clocks, rising 1 clock after the strobe edge.
- Active drops in RUN (RAMP_DIV=4) -> duty is MID=64 in the next period, then decrements every 4 strobes. OFF and PWM=00 after 256 strobes.
- Active toggles 1->0 at Ramp=10 during RAMP_UP, then 0->1 at Ramp=7 -> ramp reverses without skipping values (10,9,8,7,8…). Ramping stays 1 throughout.
- Strobe period 90 clocks with Code_R=120 -> pulse truncated to 90 clocks, then restarts. With PWM_CENTRE_ALIGNED_EN, PERIOD=130 and Duty=30: high during Count 50..79.
